// File: rtl/pattern_cfg_bank_if.sv
// pattern_cfg_bank_if: valid/ready field-masked write port of the configuration bank
interface pattern_cfg_bank_if #(
  parameter int CH_W = 2,
  parameter int E_W  = 5
);
  logic            wr_valid;
  logic            wr_ready;
  logic [CH_W-1:0] wr_ch;
  logic [1:0]      wr_sel;
  logic [E_W-1:0]  wr_data;
  modport master (output wr_valid, wr_ch, wr_sel, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_ch, wr_sel, wr_data, output wr_ready);
endinterface

// File: rtl/pattern_cfg_bank.sv
// pattern_cfg_bank: NUM_CH-entry {a,b} config bank with field-masked writes and registered read.
// Define PATTERN_SHADOW_EN to stage writes in a shadow bank copied to the active bank on commit.
module pattern_cfg_bank #(
  parameter int NUM_CH = 4,
  parameter int A_W = 2,
  parameter int B_W = 3,
  parameter logic [A_W+B_W-1:0] RST_PAT = {{A_W{1'b1}}, {B_W{1'b0}}},
  localparam int E_W = A_W + B_W,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
`ifdef PATTERN_SHADOW_EN
  input  logic                     commit,
`endif
  pattern_cfg_bank_if.slave        wr,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [E_W-1:0]           rd_data,
  output logic [NUM_CH*E_W-1:0]    cfg_o,
  output logic                     upd_o,
  output logic                     err_o
);
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } entry_t;
  typedef enum logic {IDLE, APPLY} state_t;
  localparam entry_t RST_E = RST_PAT;
  localparam logic [CH_W:0] NUM_L = (CH_W+1)'(NUM_CH);
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [1:0] sel_q, sel_d;
  entry_t data_q, data_d;
  entry_t act_q [NUM_CH];
  entry_t act_d [NUM_CH];
  entry_t rd_q, rd_d;
  logic upd_q, upd_d, err_q, err_d, hit;
`ifdef PATTERN_SHADOW_EN
  entry_t shd_q [NUM_CH];
  entry_t shd_d [NUM_CH];
  logic pend_q, pend_d;
`endif
  function automatic entry_t merge(entry_t o, entry_t n, logic [1:0] s);
    return '{a: s[1] ? n.a : o.a, b: s[0] ? n.b : o.b};
  endfunction
  // out-of-range channels complete the handshake but only raise err_o
  assign hit = (state_q == APPLY) && ({1'b0, ch_q} < NUM_L);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    sel_d = sel_q;
    data_d = data_q;
    act_d = act_q;
    upd_d = 1'b0;
    err_d = err_q;
    rd_d = ({1'b0, rd_ch} < NUM_L) ? act_q[rd_ch] : RST_E;
`ifdef PATTERN_SHADOW_EN
    shd_d = shd_q;
    pend_d = 1'b0;
`endif
    if (clr) begin
      state_d = IDLE;
      act_d = '{default: RST_E};
`ifdef PATTERN_SHADOW_EN
      shd_d = '{default: RST_E};
`endif
      upd_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (wr.wr_valid) begin
        state_d = APPLY;
        ch_d = wr.wr_ch;
        sel_d = wr.wr_sel;
        data_d = wr.wr_data;
      end
`ifdef PATTERN_SHADOW_EN
      if (commit || pend_q) begin
        act_d = shd_q;
        upd_d = 1'b1;
      end
`endif
    end else begin
      state_d = IDLE;
      err_d = err_q | !hit;
`ifdef PATTERN_SHADOW_EN
      // a commit seen while a write is landing waits one cycle so it carries that write
      pend_d = commit;
      if (hit) shd_d[ch_q] = merge(shd_q[ch_q], data_q, sel_q);
`else
      if (hit) act_d[ch_q] = merge(act_q[ch_q], data_q, sel_q);
      upd_d = hit && |sel_q;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      sel_q <= '0;
      data_q <= RST_E;
      act_q <= '{default: RST_E};
      rd_q <= RST_E;
      upd_q <= 1'b0;
      err_q <= 1'b0;
`ifdef PATTERN_SHADOW_EN
      shd_q <= '{default: RST_E};
      pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      sel_q <= sel_d;
      data_q <= data_d;
      act_q <= act_d;
      rd_q <= rd_d;
      upd_q <= upd_d;
      err_q <= err_d;
`ifdef PATTERN_SHADOW_EN
      shd_q <= shd_d;
      pend_q <= pend_d;
`endif
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cfg
    assign cfg_o[i*E_W +: E_W] = act_q[i];
  end
  assign wr.wr_ready = (state_q == IDLE);
  assign rd_data = rd_q;
  assign upd_o = upd_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_pattern_cfg_bank.sv
// tb_pattern_cfg_bank: scoreboard bench; each expected cfg_o snapshot is queued at stimulus
// time and popped by a monitor on every upd_o pulse.
module tb_pattern_cfg_bank;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, commit = 1'b0;
  always #5 clk = ~clk;
  pattern_cfg_bank_if #(.CH_W(2), .E_W(5)) w4 ();
  pattern_cfg_bank_if #(.CH_W(2), .E_W(5)) w3 ();
  logic [1:0] rd_ch4 = 2'd2, rd_ch3 = 2'd0;
  logic [4:0] rd4, rd3;
  logic [19:0] cfg4;
  logic [14:0] cfg3;
  logic upd4, upd3, err4, err3;
  pattern_cfg_bank dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
`ifdef PATTERN_SHADOW_EN
    .commit(commit),
`endif
    .wr(w4.slave), .rd_ch(rd_ch4), .rd_data(rd4), .cfg_o(cfg4), .upd_o(upd4), .err_o(err4)
  );
  pattern_cfg_bank #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
`ifdef PATTERN_SHADOW_EN
    .commit(1'b0),
`endif
    .wr(w3.slave), .rd_ch(rd_ch3), .rd_data(rd3), .cfg_o(cfg3), .upd_o(upd3), .err_o(err3)
  );
  localparam logic [19:0] R4 = 20'b11000_11000_11000_11000;
  localparam logic [14:0] R3 = 15'b11000_11000_11000;
  logic [19:0] q4 [$];
  logic [14:0] q3 [$];
  logic [19:0] e4;
  logic [14:0] e3;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (upd4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL upd4_unexpected: got pulse with cfg %b want no pulse", cfg4);
      end else begin
        e4 = q4.pop_front();
        if (cfg4 !== e4) begin
          n_bad++;
          $display("FAIL upd4_cfg: got %b want %b", cfg4, e4);
        end
      end
    end
    if (upd3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL upd3_unexpected: got pulse with cfg %b want no pulse", cfg3);
      end else begin
        e3 = q3.pop_front();
        if (cfg3 !== e3) begin
          n_bad++;
          $display("FAIL upd3_cfg: got %b want %b", cfg3, e3);
        end
      end
    end
  end
  initial begin
    w4.wr_valid = 1'b0; w4.wr_ch = '0; w4.wr_sel = '0; w4.wr_data = '0;
    w3.wr_valid = 1'b0; w3.wr_ch = '0; w3.wr_sel = '0; w3.wr_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cfg", 32'(cfg4), 32'(R4));
    chk("rst_ready", 32'(w4.wr_ready), 1);
    chk("rst_err", 32'(err4), 0);
    chk("rst_upd", 32'(upd4), 0);
    chk("rst_rd", 32'(rd4), 32'b11000);
    // NUM_CH=3 bank: write to channel 3 is accepted but dropped with a sticky error
    w3.wr_valid = 1'b1; w3.wr_ch = 2'd3; w3.wr_sel = 2'b11; w3.wr_data = 5'b00000;
    chk("oob_ready", 32'(w3.wr_ready), 1);
    tick();
    w3.wr_valid = 1'b0;
    tick();
    chk("oob_err", 32'(err3), 1);
    chk("oob_cfg", 32'(cfg3), 32'(R3));
    rd_ch3 = 2'd3;
    repeat (3) tick();
    chk("oob_err_sticky", 32'(err3), 1);
    chk("oob_rd", 32'(rd3), 32'b11000);
`ifndef PATTERN_SHADOW_EN
    // masked write of field b only
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd2; w4.wr_sel = 2'b01; w4.wr_data = 5'b00_101;
    q4.push_back(20'b11000_11101_11000_11000);
    tick();
    w4.wr_valid = 1'b0;
    chk("wr_apply_ready", 32'(w4.wr_ready), 0);
    chk("wr_not_yet", 32'(cfg4), 32'(R4));
    repeat (2) tick();
    chk("wr_rd", 32'(rd4), 32'b11_101);
    // wr_valid held four cycles: ready toggles and exactly two writes land
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd0; w4.wr_sel = 2'b11; w4.wr_data = 5'b01_010;
    q4.push_back(20'b11000_11101_11000_01010);
    q4.push_back(20'b10000_11101_11000_01010);
    chk("b2b_rdy0", 32'(w4.wr_ready), 1);
    tick();
    chk("b2b_rdy1", 32'(w4.wr_ready), 0);
    w4.wr_ch = 2'd3; w4.wr_sel = 2'b10; w4.wr_data = 5'b10_111;
    tick();
    chk("b2b_rdy2", 32'(w4.wr_ready), 1);
    tick();
    chk("b2b_rdy3", 32'(w4.wr_ready), 0);
    tick();
    w4.wr_valid = 1'b0;
    repeat (2) tick();
    chk("b2b_cfg", 32'(cfg4), 32'(20'b10000_11101_11000_01010));
    // empty select: accepted, nothing changes, no pulse
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd1; w4.wr_sel = 2'b00; w4.wr_data = 5'b11111;
    tick();
    w4.wr_valid = 1'b0;
    repeat (3) tick();
    chk("sel0_cfg", 32'(cfg4), 32'(20'b10000_11101_11000_01010));
    chk("sel0_err", 32'(err4), 0);
    // clr during the APPLY cycle of a ch0 write
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd0; w4.wr_sel = 2'b11; w4.wr_data = 5'b00001;
    tick();
    w4.wr_valid = 1'b0; clr = 1'b1;
    q4.push_back(R4); q3.push_back(R3);
    tick();
    clr = 1'b0;
    chk("clr_ready", 32'(w4.wr_ready), 1);
    chk("clr_cfg", 32'(cfg4), 32'(R4));
    repeat (2) tick();
    chk("clr_cfg_hold", 32'(cfg4), 32'(R4));
    // handshake coincident with clr is dropped
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd1; w4.wr_sel = 2'b11; w4.wr_data = 5'b00111; clr = 1'b1;
    chk("clrhs_ready", 32'(w4.wr_ready), 1);
    q4.push_back(R4); q3.push_back(R3);
    tick();
    w4.wr_valid = 1'b0; clr = 1'b0;
    chk("clrhs_idle", 32'(w4.wr_ready), 1);
    repeat (3) tick();
    chk("clrhs_cfg", 32'(cfg4), 32'(R4));
    chk("clr_keeps_err", 32'(err3), 1);
    // async reset in the middle of APPLY loses the write
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd3; w4.wr_sel = 2'b11; w4.wr_data = 5'b00011;
    q4.push_back(20'b00011_11000_11000_11000);
    tick();
    w4.wr_valid = 1'b0;
    repeat (2) tick();
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd1; w4.wr_sel = 2'b11; w4.wr_data = 5'b10101;
    tick();
    w4.wr_valid = 1'b0;
    chk("mid_apply", 32'(w4.wr_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg", 32'(cfg4), 32'(R4));
    chk("arst_ready", 32'(w4.wr_ready), 1);
    chk("arst_err3", 32'(err3), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_lost", 32'(cfg4), 32'(R4));
`else
    // shadow bank: writes invisible until commit
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd1; w4.wr_sel = 2'b11; w4.wr_data = 5'b01_010;
    tick();
    w4.wr_valid = 1'b0;
    repeat (3) tick();
    chk("shd_hidden", 32'(cfg4), 32'(R4));
    commit = 1'b1;
    q4.push_back(20'b11000_11000_01010_11000);
    tick();
    commit = 1'b0;
    chk("shd_commit", 32'(cfg4), 32'(20'b11000_11000_01010_11000));
    repeat (2) tick();
    // commit during APPLY is deferred and includes the in-flight write
    w4.wr_valid = 1'b1; w4.wr_ch = 2'd2; w4.wr_sel = 2'b11; w4.wr_data = 5'b00_111;
    tick();
    w4.wr_valid = 1'b0; commit = 1'b1;
    q4.push_back(20'b11000_00111_01010_11000);
    tick();
    commit = 1'b0;
    tick();
    chk("shd_defer", 32'(cfg4), 32'(20'b11000_00111_01010_11000));
    clr = 1'b1;
    q4.push_back(R4); q3.push_back(R3);
    tick();
    clr = 1'b0;
    commit = 1'b1;
    q4.push_back(R4);
    tick();
    commit = 1'b0;
    repeat (2) tick();
    chk("shd_clr_both", 32'(cfg4), 32'(R4));
`endif
    repeat (3) tick();
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
